// File: rtl/prvp_dc_fifo_pkg.sv
// Shared definitions for both halves of the dual-clock token-ring FIFO.
//   WRITE_TOKEN_RESET  - reset value of the two-adjacent-ones write token (bits 2,3)
//   READ_POINTER_RESET - reset value of the one-hot read pointer (bit 3)
//   rotl1 / rotr1      - rotate the low 'width' bits of a vector by one place
package prvp_dc_fifo_pkg;

   localparam int unsigned WRITE_TOKEN_RESET  = 'hC;
   localparam int unsigned READ_POINTER_RESET = 'h8;
   localparam int unsigned MAX_DEPTH          = 64;

   // Bits at and above 'width' are cleared, so callers may cast down freely.
   function automatic logic [MAX_DEPTH-1:0] rotl1(input logic [MAX_DEPTH-1:0] v,
                                                  input int unsigned width);
      logic [MAX_DEPTH-1:0] mask;
      mask = (MAX_DEPTH'(1) << width) - MAX_DEPTH'(1);
      return ((v << 1) | ((v & mask) >> (width - 1))) & mask;
   endfunction

   function automatic logic [MAX_DEPTH-1:0] rotr1(input logic [MAX_DEPTH-1:0] v,
                                                  input int unsigned width);
      logic [MAX_DEPTH-1:0] mask;
      mask = (MAX_DEPTH'(1) << width) - MAX_DEPTH'(1);
      return (((v & mask) >> 1) | (v << (width - 1))) & mask;
   endfunction

endpackage

// File: rtl/prvp_dc_synchronizer.sv
// Two-flop synchronizer for a multi-bit, gray/one-hot style bus.
//   clk   - destination clock
//   rstn  - asynchronous active-low reset, loads RESET_VALUE into both stages
//   d     - asynchronous input bus
//   q     - synchronized output bus
module prvp_dc_synchronizer #(
   parameter int unsigned       WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/prvp_dc_token_ring.sv
// Rotating token register: rotates left by one place when enable is high.
//   clk    - clock
//   rstn   - asynchronous active-low reset, loads RESET_VALUE
//   enable - advance the token by one position
//   state  - registered token, safe to send across a clock domain
module prvp_dc_token_ring #(
   parameter int unsigned       WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = 'hC
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   output logic [WIDTH-1:0] state
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= RESET_VALUE;
      else if (enable)
         state <= {state[WIDTH-2:0], state[WIDTH-1]};
   end

endmodule

// File: rtl/prvp_dc_token_ring_fifo_din.sv
// Write half of the dual-clock token-ring FIFO (producer clock domain).
// Stores words in a BUFFER_DEPTH register buffer, publishes a two-bit write
// token to the read half and detects full from the synchronized read pointer.
//   clk          - write-domain clock
//   rst          - asynchronous active-high reset
//   data/valid   - producer word and its valid
//   ready        - word accepted on valid & ready at rising clk
//   write_token  - registered token ring to the read half
//   read_pointer - one-hot read slot from the read half (asynchronous)
//   data_async   - combinational buffer word at read_pointer
// Build option: PRVP_DC_FIFO_DIN_BUFFER_RESET_EN clears the buffer on rst.
module prvp_dc_token_ring_fifo_din
   import prvp_dc_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 10,
   parameter int unsigned BUFFER_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   data,
   input  logic                    valid,
   output logic                    ready,
   output logic [BUFFER_DEPTH-1:0] write_token,
   input  logic [BUFFER_DEPTH-1:0] read_pointer,
   output logic [DATA_WIDTH-1:0]   data_async
);

   logic                    rstn;
   logic                    accept;
   logic [BUFFER_DEPTH-1:0] write_pointer;
   logic [BUFFER_DEPTH-1:0] rp_sync;
   logic [DATA_WIDTH-1:0]   buffer [BUFFER_DEPTH];

   assign rstn   = ~rst;
   assign accept = valid & ready;

   prvp_dc_token_ring #(
      .WIDTH       (BUFFER_DEPTH),
      .RESET_VALUE (BUFFER_DEPTH'(WRITE_TOKEN_RESET))
   ) u_token_ring (
      .clk    (clk),
      .rstn   (rstn),
      .enable (accept),
      .state  (write_token)
   );

   prvp_dc_synchronizer #(
      .WIDTH       (BUFFER_DEPTH),
      .RESET_VALUE (BUFFER_DEPTH'(READ_POINTER_RESET))
   ) u_rp_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (read_pointer),
      .q    (rp_sync)
   );

   // The upper of the two token bits is the slot written next.
   assign write_pointer = write_token &
                          BUFFER_DEPTH'(rotl1(MAX_DEPTH'(write_token), BUFFER_DEPTH));

   // Full when the slot after the write pointer is still being read; rp_sync
   // lags the real pointer, so this can only under-report free space.
   assign ready = ~|(BUFFER_DEPTH'(rotl1(MAX_DEPTH'(write_pointer), BUFFER_DEPTH)) & rp_sync);

`ifdef PRVP_DC_FIFO_DIN_BUFFER_RESET_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUFFER_DEPTH; i++)
            buffer[i] <= '0;
      end else begin
         for (int i = 0; i < BUFFER_DEPTH; i++)
            if (accept && write_pointer[i])
               buffer[i] <= data;
      end
   end
`else
   always_ff @(posedge clk) begin
      for (int i = 0; i < BUFFER_DEPTH; i++)
         if (accept && write_pointer[i])
            buffer[i] <= data;
   end
`endif

   // AND-OR mux: no clk dependence, read in the consumer domain.
   always_comb begin
      data_async = '0;
      for (int i = 0; i < BUFFER_DEPTH; i++)
         if (read_pointer[i])
            data_async = data_async | buffer[i];
   end

endmodule

// File: tb/tb_prvp_dc_token_ring_fifo_din.sv
module tb_prvp_dc_token_ring_fifo_din;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  data = '0;
   logic        valid = 1'b0;
   logic        ready;
   logic [7:0]  write_token;
   logic [7:0]  read_pointer = 8'h08;
   logic [9:0]  data_async;

   always #5 clk = ~clk;

   prvp_dc_token_ring_fifo_din #(
      .DATA_WIDTH   (10),
      .BUFFER_DEPTH (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data         (data),
      .valid        (valid),
      .ready        (ready),
      .write_token  (write_token),
      .read_pointer (read_pointer),
      .data_async   (data_async)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int slot_of(input logic [7:0] v);
      for (int i = 0; i < 8; i++)
         if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [7:0] onehot(input int s);
      logic [7:0] t;
      t = '0;
      t[s % 8] = 1'b1;
      return t;
   endfunction

   function automatic logic [7:0] tok_of(input int s);
      logic [7:0] t;
      t = '0;
      t[s % 8] = 1'b1;
      t[(s + 7) % 8] = 1'b1;
      return t;
   endfunction

   // ---------------- behavioural model ----------------
   // Slots are tracked as plain indices: the next write slot, the read slot as
   // seen two edges late, and the content known to be in each slot.
`ifdef PRVP_DC_FIFO_DIN_BUFFER_RESET_EN
   localparam bit RST_CLEARS = 1'b1;
`else
   localparam bit RST_CLEARS = 1'b0;
`endif

   int         m_wslot, m_q1, m_q2;
   logic [9:0] m_mem [8];
   bit         m_known [8];
   logic       m_ready;

   assign m_ready = (((m_wslot - m_q2 + 8) % 8) < 7);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_wslot <= 3;
         m_q1    <= 3;
         m_q2    <= 3;
         for (int i = 0; i < 8; i++) begin
            m_mem[i]   <= '0;
            m_known[i] <= RST_CLEARS;
         end
      end else begin
         m_q1 <= slot_of(read_pointer);
         m_q2 <= m_q1;
         if (valid && m_ready) begin
            m_mem[m_wslot]   <= data;
            m_known[m_wslot] <= 1'b1;
            m_wslot          <= (m_wslot + 1) % 8;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_ready", 32'(ready), 32'(m_ready));
         chk("cyc_write_token", 32'(write_token), 32'(tok_of(m_wslot)));
         if (m_known[slot_of(read_pointer)])
            chk("cyc_data_async", 32'(data_async), 32'(m_mem[slot_of(read_pointer)]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int   sent, recv;
   logic r_smp;
   logic acc;

   initial begin
      // 1: reset
      #1 rst = 1'b1;
      read_pointer = 8'h08;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_token", 32'(write_token), 32'h0C);
`ifdef PRVP_DC_FIFO_DIN_BUFFER_RESET_EN
      chk("rst_data", 32'(data_async), 32'h0);
`endif

      // 2: single write
      data = 10'h155;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("wr1_token", 32'(write_token), 32'h18);
      chk("wr1_data", 32'(data_async), 32'h155);

      // 3: fill to capacity
      do_reset();
      for (int k = 1; k <= 7; k++) begin
         data = 10'(k);
         valid = 1'b1;
         tick();
      end
      chk("fill_ready", 32'(ready), 32'd0);
      chk("fill_token", 32'(write_token), 32'h06);
      chk("fill_data", 32'(data_async), 32'h1);
      data = 10'h008;
      repeat (3) tick();
      chk("full_hold_token", 32'(write_token), 32'h06);
      chk("full_hold_ready", 32'(ready), 32'd0);

      // 4: drain one, free space seen two edges later
      read_pointer = 8'h10;
      tick();
      chk("drain_1clk", 32'(ready), 32'd0);
      tick();
      chk("drain_2clk", 32'(ready), 32'd1);
      tick();
      chk("drain_refull", 32'(ready), 32'd0);
      chk("drain_token", 32'(write_token), 32'h0C);
      chk("drain_data", 32'(data_async), 32'h2);
      valid = 1'b0;

      // 5: wrap stream with a reader model
      read_pointer = 8'h08;
      do_reset();
      sent = 0;
      recv = 0;
      for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
         valid = (sent < 20);
         data  = 10'(sent);
         @(negedge clk);
         r_smp = ready;
         acc   = valid & r_smp;
         tick();
         if (acc) begin
            sent++;
            if (sent % 8 == 0)
               chk("wrap_token", 32'(write_token), 32'h0C);
         end
         if (recv < sent && (cyc % 3) != 2) begin
            chk("stream_data", 32'(data_async), 32'(recv));
            recv++;
            read_pointer = onehot(3 + recv);
         end
      end
      valid = 1'b0;
      chk("stream_count", 32'(recv), 32'd20);

      // 6: reset with words in flight
      read_pointer = 8'h08;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         data = 10'h3A0 + 10'(k);
         valid = 1'b1;
         tick();
      end
      valid = 1'b0;
      read_pointer = 8'h20;
      repeat (3) tick();
      chk("pre_rst_token", 32'(write_token), 32'hC0);
      chk("pre_rst_rp_sync", 32'(dut.rp_sync), 32'h20);
      rst = 1'b1;
      read_pointer = 8'h08;
      #1;
      chk("mid_rst_token", 32'(write_token), 32'h0C);
      chk("mid_rst_rp_sync", 32'(dut.rp_sync), 32'h08);
      chk("mid_rst_ready", 32'(ready), 32'd1);
`ifdef PRVP_DC_FIFO_DIN_BUFFER_RESET_EN
      chk("mid_rst_data", 32'(data_async), 32'h0);
`endif
      tick();
      rst = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
